ex_decode_stage: RTL and testbench

//   Registered successor to the combinational EX-stage decoder. Decodes opcode/funct3/funct7 into an EX control word.

---
 rtl/ex_decode_stage.sv | 189 ++++++++++++++++++
 tb/tb_ex_decode_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_decode_stage.sv
// ex_decode_stage
//   Registered EX-stage decoder. Decodes opcode/funct3/funct7 into a 13-bit
//   EX control word and holds it in a valid/ready register between ID and EX.
//   RV32M ops (OP_R, funct7=0x01) optionally decode as mul/div. After EX
//   accepts one, ID is stalled for MULDIV_CYCLES cycles. Flush kills the held
//   op and any op presented in the same cycle.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   flush                     kill held op and the op presented this cycle
//   in_valid / in_ready       ID handshake (in_ready is combinational)
//   opcode, funct3, funct7    instruction fields
//   out_valid / out_ready     EX handshake
//   ex_op_out[12:0]           {md_en, branch_op[2:0], alu_op[3:0], src_a, src_b,
//                              alu_en, branch_en, work_en}
//   md_busy                   high while waiting out a mul/div
module ex_decode_stage #(
    parameter bit          ENABLE_M      = 1'b1,
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] ex_op_out,
    output logic        md_busy
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_IL = 7'b0000011;
    localparam logic [6:0] OP_IJ = 7'b1100111;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_UA = 7'b0010111;
    localparam logic [6:0] OP_J  = 7'b1101111;

    localparam logic [7:0] MD_INIT = 8'(MULDIV_CYCLES - 1);

    typedef enum logic [1:0] {EMPTY, FULL, MD_WAIT} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        load;
    logic        accept;
    logic        held_md;

    // ---------------- decode ----------------
    logic [3:0]  alu_r, alu_i, alu_op;
    logic        md_r, md_en;
    logic        src_a, src_b, alu_en, branch_en, work_en;
    logic [12:0] dec;

    always_comb begin
        alu_r = 4'b1111;
        md_r  = 1'b0;
        case (funct7)
            7'h00: alu_r = {1'b0, funct3};
            7'h20: alu_r = {1'b1, funct3};
            7'h01: begin
                if (ENABLE_M) begin
                    alu_r = {1'b0, funct3};
                    md_r  = 1'b1;
                end
            end
            default: alu_r = 4'b1111;
        endcase
    end

    // Only the shift-immediates carry a meaningful funct7.
    assign alu_i = (funct3 == 3'b001 || funct3 == 3'b101) ? alu_r : {1'b0, funct3};

    always_comb begin
        alu_op    = 4'b1111;
        md_en     = 1'b0;
        src_a     = 1'b0;
        src_b     = 1'b0;
        alu_en    = 1'b0;
        branch_en = 1'b0;
        work_en   = 1'b0;
        case (opcode)
            OP_R: begin
                work_en = 1'b1;
                alu_en  = 1'b1;
                alu_op  = alu_r;
                md_en   = md_r;
            end
            OP_I: begin
                work_en = 1'b1;
                alu_en  = 1'b1;
                src_b   = 1'b1;
                alu_op  = alu_i;
            end
            OP_IL, OP_IJ, OP_S: begin
                work_en = 1'b1;
                alu_en  = 1'b1;
                src_b   = 1'b1;
                alu_op  = 4'b0000;
            end
            OP_B: begin
                work_en   = 1'b1;
                alu_en    = 1'b1;
                branch_en = 1'b1;
                src_a     = 1'b1;
                src_b     = 1'b1;
                alu_op    = 4'b0000;
            end
            OP_UA, OP_J: begin
                work_en = 1'b1;
                alu_en  = 1'b1;
                src_a   = 1'b1;
                src_b   = 1'b1;
                alu_op  = 4'b0000;
            end
            // lui, system and unknown opcodes travel as bubbles
            default: alu_op = 4'b1111;
        endcase
    end

    assign dec = {md_en, funct3, alu_op, src_a, src_b, alu_en, branch_en, work_en};

    // ---------------- handshake / FSM ----------------
    assign held_md   = ex_op_out[12];
    assign out_valid = (state == FULL);
    assign md_busy   = (state == MD_WAIT);
    // A held md op must not be overwritten on the cycle EX takes it: the stage
    // enters MD_WAIT instead of pipelining the next op.
    assign in_ready  = (state == EMPTY) || ((state == FULL) && out_ready && !held_md);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load      = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (held_md) begin
                        state_nxt = MD_WAIT;
                        cnt_nxt   = MD_INIT;
                    end else if (in_valid) begin
                        load      = 1'b1;
                        state_nxt = FULL;
                    end else begin
                        state_nxt = EMPTY;
                    end
                end
            end
            MD_WAIT: begin
                if (cnt == 8'd0) state_nxt = EMPTY;
                else             cnt_nxt   = cnt - 8'd1;
            end
            default: begin
                state_nxt = EMPTY;
                cnt_nxt   = 8'd0;
            end
        endcase
        if (flush) begin
            state_nxt = EMPTY;
            cnt_nxt   = 8'd0;
            load      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            cnt       <= 8'd0;
            ex_op_out <= 13'h000;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) ex_op_out <= dec;
        end
    end

endmodule

// File: tb/tb_ex_decode_stage.sv
module tb_ex_decode_stage;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_IL = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_UA = 7'b0010111;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_U  = 7'b0110111;
    localparam logic [6:0] OP_IE = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [12:0] ex_op_out;
    logic        md_busy;

    logic        nm_in_valid = 1'b0;
    logic        nm_in_ready;
    logic        nm_out_valid;
    logic        nm_out_ready = 1'b1;
    logic [12:0] nm_ex_op_out;
    logic        nm_md_busy;
    logic        nm_flush = 1'b0;

    int checks = 0;
    int fails  = 0;
    logic [12:0] q[$];
    logic [12:0] nm_q[$];

    always #5 clk = ~clk;

    ex_decode_stage #(.ENABLE_M(1'b1), .MULDIV_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .out_valid(out_valid), .out_ready(out_ready),
        .ex_op_out(ex_op_out), .md_busy(md_busy)
    );

    ex_decode_stage #(.ENABLE_M(1'b0), .MULDIV_CYCLES(4)) dut_nm (
        .clk(clk), .rst(rst), .flush(nm_flush),
        .in_valid(nm_in_valid), .in_ready(nm_in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .out_valid(nm_out_valid), .out_ready(nm_out_ready),
        .ex_op_out(nm_ex_op_out), .md_busy(nm_md_busy)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: every EX handshake must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_out: got %h, expected no output (t=%0t)", ex_op_out, $time);
            end else begin
                chk("ex_op_out", {3'b0, ex_op_out}, {3'b0, q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && nm_out_valid && nm_out_ready) begin
            if (nm_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL nm_unexpected_out: got %h, expected no output (t=%0t)", nm_ex_op_out, $time);
            end else begin
                chk("nm_ex_op_out", {3'b0, nm_ex_op_out}, {3'b0, nm_q.pop_front()});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic v, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic ordy, input logic fl);
        in_valid  = v;
        opcode    = op;
        funct3    = f3;
        funct7    = f7;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic idle();
        set_in(1'b0, 7'd0, 3'd0, 7'd0, 1'b1, 1'b0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{OP_U,    3'b000, 7'h00, 13'h1E0};  // lui: bubble
        vecs[1] = '{7'h7F,   3'b000, 7'h00, 13'h1E0};  // unknown opcode
        vecs[2] = '{OP_I,    3'b000, 7'h7F, 13'h00D};  // addi ignores funct7
        vecs[3] = '{OP_S,    3'b010, 7'h00, 13'h40D};  // sw
        vecs[4] = '{OP_UA,   3'b000, 7'h00, 13'h01D};  // auipc
        vecs[5] = '{OP_J,    3'b000, 7'h00, 13'h01D};  // jal
        vecs[6] = '{OP_R,    3'b000, 7'h10, 13'h1E5};  // illegal funct7
        vecs[7] = '{OP_I,    3'b001, 7'h00, 13'h22D};  // slli
        vecs[8] = '{OP_IE,   3'b000, 7'h00, 13'h1E0};  // ecall: bubble
        vecs[9] = '{OP_IL,   3'b010, 7'h00, 13'h40D};  // lw

        idle();
        out_ready = 1'b0;
        repeat (3) nxt();
        rst = 1'b0;
        idle();
        neg();
        chk("rst_out_valid", {15'b0, out_valid}, 16'd0);
        chk("rst_md_busy",   {15'b0, md_busy},   16'd0);
        chk("rst_ex_op_out", {3'b0, ex_op_out},  16'h000);
        chk("rst_in_ready",  {15'b0, in_ready},  16'd1);
        nxt();

        // T1: add
        set_in(1'b1, OP_R, 3'b000, 7'h00, 1'b1, 1'b0);
        q.push_back(13'h005);
        neg(); chk("t1_in_ready", {15'b0, in_ready}, 16'd1); nxt();
        idle();
        neg(); chk("t1_out_valid", {15'b0, out_valid}, 16'd1); nxt();
        neg(); chk("t1_out_valid_pulse", {15'b0, out_valid}, 16'd0); nxt();

        // T2: back-to-back sub, bne, srai
        set_in(1'b1, OP_R, 3'b000, 7'h20, 1'b1, 1'b0); q.push_back(13'h105);
        neg(); chk("t2_in_ready0", {15'b0, in_ready}, 16'd1); nxt();
        set_in(1'b1, OP_B, 3'b001, 7'h00, 1'b1, 1'b0); q.push_back(13'h21F);
        neg(); chk("t2_in_ready1", {15'b0, in_ready}, 16'd1); nxt();
        set_in(1'b1, OP_I, 3'b101, 7'h20, 1'b1, 1'b0); q.push_back(13'hBAD);
        neg(); chk("t2_in_ready2", {15'b0, in_ready}, 16'd1); nxt();
        idle();
        neg(); chk("t2_out_valid", {15'b0, out_valid}, 16'd1); nxt();
        neg(); chk("t2_drained", {15'b0, out_valid}, 16'd0); nxt();

        // T3: EX backpressure for 3 cycles
        set_in(1'b1, OP_R, 3'b100, 7'h00, 1'b0, 1'b0); q.push_back(13'h885);
        neg(); nxt();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, OP_R, 3'b110, 7'h00, 1'b0, 1'b0);
            neg();
            chk("t3_in_ready_stall", {15'b0, in_ready}, 16'd0);
            chk("t3_out_valid_hold", {15'b0, out_valid}, 16'd1);
            chk("t3_ex_op_hold", {3'b0, ex_op_out}, 16'h885);
            nxt();
        end
        set_in(1'b1, OP_R, 3'b110, 7'h00, 1'b1, 1'b0); q.push_back(13'hCC5);
        neg(); chk("t3_release_in_ready", {15'b0, in_ready}, 16'd1); nxt();
        idle();
        neg(); chk("t3_out_valid", {15'b0, out_valid}, 16'd1); nxt();
        neg(); nxt();

        // T4: mul, 4-cycle stall; op offered during the wait is taken afterwards
        set_in(1'b1, OP_R, 3'b000, 7'h01, 1'b1, 1'b0); q.push_back(13'h1005);
        neg(); chk("t4_in_ready", {15'b0, in_ready}, 16'd1); nxt();
        set_in(1'b1, OP_R, 3'b000, 7'h00, 1'b1, 1'b0);
        neg();
        chk("t4_md_handshake_in_ready", {15'b0, in_ready}, 16'd0);
        chk("t4_md_out_valid", {15'b0, out_valid}, 16'd1);
        nxt();
        for (int i = 0; i < 4; i++) begin
            neg();
            chk("t4_md_busy", {15'b0, md_busy}, 16'd1);
            chk("t4_wait_in_ready", {15'b0, in_ready}, 16'd0);
            nxt();
        end
        q.push_back(13'h005);
        neg();
        chk("t4_md_done_busy", {15'b0, md_busy}, 16'd0);
        chk("t4_md_done_in_ready", {15'b0, in_ready}, 16'd1);
        nxt();
        idle();
        neg(); chk("t4_after_out_valid", {15'b0, out_valid}, 16'd1); nxt();
        neg(); nxt();

        // T4b: ENABLE_M=0 instance sees mul as illegal funct7
        set_in(1'b0, OP_R, 3'b000, 7'h01, 1'b1, 1'b0);
        nm_in_valid = 1'b1; nm_q.push_back(13'h1E5);
        neg(); chk("nm_in_ready", {15'b0, nm_in_ready}, 16'd1); nxt();
        nm_in_valid = 1'b0; idle();
        neg();
        chk("nm_out_valid", {15'b0, nm_out_valid}, 16'd1);
        chk("nm_md_busy", {15'b0, nm_md_busy}, 16'd0);
        nxt();
        neg(); chk("nm_no_stall", {15'b0, nm_in_ready}, 16'd1); nxt();

        // T5: flush while FULL, while EMPTY with a presented op, and mid MD_WAIT
        set_in(1'b1, OP_R, 3'b111, 7'h00, 1'b0, 1'b0);
        neg(); chk("t5_in_ready", {15'b0, in_ready}, 16'd1); nxt();
        set_in(1'b1, OP_R, 3'b110, 7'h00, 1'b0, 1'b1);
        neg(); chk("t5_full_before_flush", {15'b0, out_valid}, 16'd1); nxt();
        idle();
        neg();
        chk("t5_flush_out_valid", {15'b0, out_valid}, 16'd0);
        chk("t5_flush_in_ready", {15'b0, in_ready}, 16'd1);
        chk("t5_flush_ex_op_hold", {3'b0, ex_op_out}, 16'hEE5);
        nxt();
        set_in(1'b1, OP_R, 3'b000, 7'h00, 1'b1, 1'b1);
        neg(); chk("t5_empty_flush_in_ready", {15'b0, in_ready}, 16'd1); nxt();
        idle();
        neg(); chk("t5_empty_flush_dropped", {15'b0, out_valid}, 16'd0); nxt();
        set_in(1'b1, OP_R, 3'b000, 7'h01, 1'b1, 1'b0); q.push_back(13'h1005);
        neg(); nxt();
        idle();
        neg(); chk("t5_md_out_valid", {15'b0, out_valid}, 16'd1); nxt();
        neg(); chk("t5_md_wait_cnt3", {15'b0, md_busy}, 16'd1); nxt();
        set_in(1'b1, OP_R, 3'b000, 7'h00, 1'b1, 1'b1);
        neg();
        chk("t5_md_wait_cnt2", {15'b0, md_busy}, 16'd1);
        chk("t5_md_wait_in_ready", {15'b0, in_ready}, 16'd0);
        nxt();
        idle();
        neg();
        chk("t5_md_flush_busy", {15'b0, md_busy}, 16'd0);
        chk("t5_md_flush_in_ready", {15'b0, in_ready}, 16'd1);
        chk("t5_md_flush_out_valid", {15'b0, out_valid}, 16'd0);
        nxt();

        // T6: bubbles and other opcode classes, back to back
        foreach (vecs[i]) begin
            set_in(1'b1, vecs[i].op, vecs[i].f3, vecs[i].f7, 1'b1, 1'b0);
            q.push_back(vecs[i].exp);
            neg(); chk("t6_in_ready", {15'b0, in_ready}, 16'd1); nxt();
        end
        idle();
        neg(); nxt();
        neg(); chk("t6_drained", {15'b0, out_valid}, 16'd0); nxt();

        // reset while FULL drops the op
        set_in(1'b1, OP_R, 3'b010, 7'h00, 1'b0, 1'b0);
        neg(); nxt();
        rst = 1'b1;
        set_in(1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0);
        neg(); chk("t6_full_before_rst", {15'b0, out_valid}, 16'd1); nxt();
        rst = 1'b0;
        idle();
        neg();
        chk("t6_rst_out_valid", {15'b0, out_valid}, 16'd0);
        chk("t6_rst_ex_op_out", {3'b0, ex_op_out}, 16'h000);
        chk("t6_rst_in_ready", {15'b0, in_ready}, 16'd1);
        nxt();

        repeat (3) nxt();
        neg();
        chk("sb_empty", 16'(q.size()), 16'd0);
        chk("nm_sb_empty", 16'(nm_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
